// File: rtl/sa_seq_pkg.sv
// Shared state type, engine mode encodings and widths for the systolic-array host sequencer.
package sa_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_LOAD,
        ST_MATMUL,
        ST_READ,
        ST_DONE
    } seq_state_t;

    // {sa_load, sa_write} as seen by the engine
    localparam logic [1:0] MODE_WRITE  = 2'b01;
    localparam logic [1:0] MODE_LOAD   = 2'b10;
    localparam logic [1:0] MODE_MATMUL = 2'b00;
    localparam logic [1:0] MODE_READ   = 2'b11;

    localparam int DATA_W = 8;
    localparam int RES_W  = 19;
    localparam int IDX_W  = 3;
    localparam int SEL_W  = 4;

endpackage

// File: rtl/sa_res_fifo.sv
// Synchronous first-word-fall-through result FIFO; DEPTH must be a power of two.
module sa_res_fifo
    import sa_seq_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [RES_W-1:0] push_data,
    input  logic             pop,
    output logic [RES_W-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [RES_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sa_host_sequencer.sv
// Host-side job sequencer for the systolic-array engine: write, load, matmul, read back.
// Optional wait/read timeout is compiled in with SA_SEQ_TIMEOUT_EN.
module sa_host_sequencer
    import sa_seq_pkg::*;
#(
    parameter int ROWS           = 16,
    parameter int COLS           = 8,
    parameter int RESULT_WORDS   = 16,
    parameter int RES_DEPTH      = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              sa_en,
    output logic              sa_load,
    output logic              sa_write,
    output logic [DATA_W-1:0] sa_data,
    output logic [IDX_W-1:0]  sa_idx,
    output logic [SEL_W-1:0]  sa_reg_select,
    input  logic              sa_int,
    input  logic              sa_output_en,
    input  logic [RES_W-1:0]  sa_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_data,
    output logic              busy,
    output logic              done,
    output logic              err_overflow,
    output logic              err_timeout
);

    localparam int RCW = $clog2(RESULT_WORDS + 1);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0] COL_LAST = IDX_W'(COLS - 1);
    localparam logic [SEL_W-1:0] ROW_LAST = SEL_W'(ROWS - 1);
    localparam logic [RCW-1:0]   RES_LAST = RCW'(RESULT_WORDS - 1);
    localparam logic [TW-1:0]    TO_LIMIT = TW'(TIMEOUT_CYCLES);

`ifdef SA_SEQ_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    seq_state_t        state_q, state_d;
    logic [SEL_W-1:0]  row_q, row_d;
    logic [IDX_W-1:0]  col_q, col_d;
    logic [RCW-1:0]    res_cnt_q, res_cnt_d;
    logic [TW-1:0]     tcnt_q;
    logic              armed_q, armed_d;
    logic              err_ovf_q, err_ovf_d;
    logic              err_to_q, err_to_d;
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              en_q, en_d;
    logic              hs;
    logic              wait_hit;
    logic              timeout_hit;
    logic              fifo_push;
    logic              fifo_full;
    logic              fifo_empty;

    assign hs          = (state_q == ST_WRITE) && in_valid;
    // A wait state only completes on a 1 seen after it has observed a 0.
    assign wait_hit    = armed_q && sa_int;
    assign timeout_hit = TIMEOUT_EN && (tcnt_q == TO_LIMIT) &&
                         (state_q inside {ST_LOAD, ST_MATMUL, ST_READ});
    assign fifo_push   = (state_q == ST_READ) && sa_output_en && !fifo_full;

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        res_cnt_d = res_cnt_q;
        armed_d   = armed_q | ~sa_int;
        err_ovf_d = err_ovf_q;
        err_to_d  = err_to_q;
        data_d    = data_q;
        idx_d     = idx_q;
        sel_d     = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_WRITE;
                    row_d     = '0;
                    col_d     = '0;
                    res_cnt_d = '0;
                    err_ovf_d = 1'b0;
                    err_to_d  = 1'b0;
                end
            end
            ST_WRITE: begin
                if (in_valid) begin
                    data_d = in_data;
                    idx_d  = col_q;
                    sel_d  = row_q;
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) state_d = ST_LOAD;
                        else                   row_d   = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            ST_LOAD:   if (wait_hit) state_d = ST_MATMUL;
            ST_MATMUL: if (wait_hit) state_d = ST_READ;
            ST_READ: begin
                // The engine cannot be stalled: a word arriving at a full FIFO is lost.
                if (sa_output_en) begin
                    if (fifo_full) err_ovf_d = 1'b1;
                    if (res_cnt_q == RES_LAST) state_d   = ST_DONE;
                    else                       res_cnt_d = res_cnt_q + 1'b1;
                end
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        if (timeout_hit) begin
            state_d  = ST_DONE;
            err_to_d = 1'b1;
        end
        if (state_d != state_q) armed_d = 1'b0;

        en_d = (state_d != ST_IDLE);
        case (state_d)
            ST_LOAD:   mode_d = MODE_LOAD;
            ST_MATMUL: mode_d = MODE_MATMUL;
            default:   mode_d = MODE_READ;
        endcase
        if (hs) mode_d = MODE_WRITE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            res_cnt_q <= '0;
            armed_q   <= 1'b0;
            err_ovf_q <= 1'b0;
            err_to_q  <= 1'b0;
            mode_q    <= MODE_READ;
            data_q    <= '0;
            idx_q     <= '0;
            sel_q     <= '0;
            en_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            res_cnt_q <= res_cnt_d;
            armed_q   <= armed_d;
            err_ovf_q <= err_ovf_d;
            err_to_q  <= err_to_d;
            mode_q    <= mode_d;
            data_q    <= data_d;
            idx_q     <= idx_d;
            sel_q     <= sel_d;
            en_q      <= en_d;
        end
    end

    // Restarts at every state change so each timed state gets its own budget.
    always_ff @(posedge clk) begin
        if (rst || (state_d != state_q)) tcnt_q <= '0;
        else if (tcnt_q != TO_LIMIT)      tcnt_q <= tcnt_q + 1'b1;
    end

    sa_res_fifo #(
        .DEPTH(RES_DEPTH)
    ) u_res_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_data(sa_result),
        .pop      (res_ready),
        .head     (res_data),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign {sa_load, sa_write} = mode_q;
    assign sa_en         = en_q;
    assign sa_data       = data_q;
    assign sa_idx        = idx_q;
    assign sa_reg_select = sel_q;
    assign in_ready      = (state_q == ST_WRITE);
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign res_valid     = !fifo_empty;
    assign err_overflow  = err_ovf_q;
    assign err_timeout   = err_to_q;

endmodule

// File: tb/tb_sa_host_sequencer.sv
// Self-checking bench for sa_host_sequencer: randomized jobs against a job-level reference model.
module tb_sa_host_sequencer;
    import sa_seq_pkg::*;

    localparam int ROWS           = 2;
    localparam int COLS           = 2;
    localparam int RESULT_WORDS   = 4;
    localparam int RES_DEPTH      = 2;
    localparam int TIMEOUT_CYCLES = 10;
    localparam int NB             = ROWS * COLS;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              sa_en;
    logic              sa_load;
    logic              sa_write;
    logic [DATA_W-1:0] sa_data;
    logic [IDX_W-1:0]  sa_idx;
    logic [SEL_W-1:0]  sa_reg_select;
    logic              sa_int;
    logic              sa_output_en;
    logic [RES_W-1:0]  sa_result;
    logic              res_valid;
    logic              res_ready;
    logic [RES_W-1:0]  res_data;
    logic              busy;
    logic              done;
    logic              err_overflow;
    logic              err_timeout;

    always #5 clk = ~clk;

    sa_host_sequencer #(
        .ROWS(ROWS), .COLS(COLS), .RESULT_WORDS(RESULT_WORDS),
        .RES_DEPTH(RES_DEPTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .sa_en(sa_en), .sa_load(sa_load), .sa_write(sa_write), .sa_data(sa_data),
        .sa_idx(sa_idx), .sa_reg_select(sa_reg_select),
        .sa_int(sa_int), .sa_output_en(sa_output_en), .sa_result(sa_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy), .done(done), .err_overflow(err_overflow), .err_timeout(err_timeout)
    );

    // Reference FIFO contents, expected overflow flag, and whether the job is in readback.
    logic [RES_W-1:0] exp_q[$];
    bit               exp_ovf;
    bit               in_read;
    int               n_checks = 0;
    int               n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    endtask

    function automatic logic [1:0] mode_now();
        return {sa_load, sa_write};
    endfunction

    // One clock: update the FIFO model for this edge, then compare the FIFO outputs.
    task automatic step();
        bit               r;
        bit               full_m;
        bit               pop_m;
        bit               push_m;
        logic [RES_W-1:0] word;
        r      = rst;
        full_m = (exp_q.size() >= RES_DEPTH);
        pop_m  = res_ready && (exp_q.size() > 0);
        push_m = in_read && sa_output_en && !full_m;
        if (!r && in_read && sa_output_en && full_m) exp_ovf = 1'b1;
        word = sa_result;
        @(posedge clk);
        if (r) begin
            exp_q.delete();
        end else begin
            if (pop_m)  void'(exp_q.pop_front());
            if (push_m) exp_q.push_back(word);
        end
        @(negedge clk);
        check("res_valid", 32'(res_valid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) check("res_data", 32'(res_data), 32'(exp_q[0]));
    endtask

    task automatic do_start();
        start   = 1'b1;
        exp_ovf = 1'b0;
        step();
        start = 1'b0;
        check("start_busy", 32'(busy), 32'(1));
        check("start_in_ready", 32'(in_ready), 32'(1));
        check("start_sa_en", 32'(sa_en), 32'(1));
        check("start_mode", 32'(mode_now()), 32'(MODE_READ));
        check("start_err_ovf", 32'(err_overflow), 32'(0));
        check("start_err_to", 32'(err_timeout), 32'(0));
    endtask

    // gap_mode: 0 = always valid, 1 = alternating bubbles, 2 = random bubbles and stray starts.
    task automatic do_write(input int gap_mode, input bit fixed_data);
        int               k = 0;
        int               t = 0;
        int               bubbles = 0;
        bit               v;
        logic [DATA_W-1:0] b;
        while (k < NB) begin
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (t % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0) || (bubbles >= 3);
            endcase
            b = fixed_data ? DATA_W'(8'hA0 + k) : DATA_W'($urandom_range(0, 255));
            in_valid = v;
            in_data  = b;
            start    = (gap_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
            if (v) begin
                check("wr_mode", 32'(mode_now()), 32'(MODE_WRITE));
                check("wr_data", 32'(sa_data), 32'(b));
                check("wr_idx", 32'(sa_idx), 32'(k % COLS));
                check("wr_sel", 32'(sa_reg_select), 32'(k / COLS));
                k++;
                bubbles = 0;
            end else begin
                check("wr_bubble_mode", 32'(mode_now()), 32'(MODE_READ));
                bubbles++;
            end
            check("wr_in_ready", 32'(in_ready), 32'(k < NB));
            check("wr_busy", 32'(busy), 32'(1));
            t++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    // sa_int: h0 cycles high, l cycles low, then high; the state must leave on that rise.
    task automatic do_wait(input logic [1:0] cur_mode, input logic [1:0] next_mode,
                           input int h0, input int l);
        int k = h0 + l;
        for (int i = 0; i <= k; i++) begin
            sa_int = (i < h0) ? 1'b1 : ((i < k) ? 1'b0 : 1'b1);
            step();
            if (i < k) check("wait_mode", 32'(mode_now()), 32'(cur_mode));
            else       check("wait_exit_mode", 32'(mode_now()), 32'(next_mode));
            check("wait_sa_en", 32'(sa_en), 32'(1));
        end
    endtask

    // ready_mode: 0 = always pop, 1 = never pop, 2 = random pops.
    task automatic do_read(input int oe_pct, input int ready_mode, input bit seq_data);
        int cnt = 0;
        int t   = 0;
        bit oe;
        in_read = 1'b1;
        while (cnt < RESULT_WORDS && t < 100) begin
            oe = (t >= 4) || ($urandom_range(0, 99) < oe_pct);
            sa_output_en = oe;
            sa_result    = seq_data ? RES_W'(cnt + 1) : RES_W'($urandom);
            res_ready    = (ready_mode == 0) ? 1'b1 :
                           ((ready_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1)));
            step();
            if (oe) cnt++;
            t++;
            check("rd_mode", 32'(mode_now()), 32'(MODE_READ));
            check("rd_done", 32'(done), 32'(cnt == RESULT_WORDS));
        end
        if (cnt < RESULT_WORDS) check("rd_word_budget", 32'(cnt), 32'(RESULT_WORDS));
        in_read      = 1'b0;
        sa_output_en = 1'b0;
        check("done_busy", 32'(busy), 32'(1));
        check("done_err_ovf", 32'(err_overflow), 32'(exp_ovf));
        check("done_err_to", 32'(err_timeout), 32'(0));
        step();
        check("idle_done", 32'(done), 32'(0));
        check("idle_busy", 32'(busy), 32'(0));
        check("idle_sa_en", 32'(sa_en), 32'(0));
        check("idle_mode", 32'(mode_now()), 32'(MODE_READ));
        check("idle_in_ready", 32'(in_ready), 32'(0));
    endtask

    task automatic do_drain();
        int guard = 0;
        res_ready = 1'b1;
        while (exp_q.size() > 0 && guard < 50) begin
            step();
            guard++;
        end
        check("drain_empty", 32'(res_valid), 32'(0));
        res_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; sa_int = 1'b0;
        sa_output_en = 1'b0; sa_result = '0; res_ready = 1'b0;
        in_read = 1'b0; exp_ovf = 1'b0;
        step();
        step();
        check("rst_mode", 32'(mode_now()), 32'(MODE_READ));
        check("rst_sa_en", 32'(sa_en), 32'(0));
        check("rst_sa_data", 32'(sa_data), 32'(0));
        check("rst_sa_idx", 32'(sa_idx), 32'(0));
        check("rst_sa_sel", 32'(sa_reg_select), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(0));
        check("rst_err_ovf", 32'(err_overflow), 32'(0));
        check("rst_err_to", 32'(err_timeout), 32'(0));
        rst = 1'b0;
        step();
        check("post_rst_busy", 32'(busy), 32'(0));

        // Ordered writes of A0..A3, long MATMUL wait, sequential readback.
        do_start();
        do_write(0, 1'b1);
        do_wait(MODE_LOAD, MODE_MATMUL, 0, 1);
`ifdef SA_SEQ_TIMEOUT_EN
        do_wait(MODE_MATMUL, MODE_READ, 1, 2);
`else
        do_wait(MODE_MATMUL, MODE_READ, 22, 2);
`endif
        do_read(50, 0, 1'b1);
        do_drain();

        // Alternating input bubbles, random pops.
        do_start();
        do_write(1, 1'b0);
        do_wait(MODE_LOAD, MODE_MATMUL, $urandom_range(0, 3), $urandom_range(1, 4));
        do_wait(MODE_MATMUL, MODE_READ, $urandom_range(0, 3), $urandom_range(1, 4));
        do_read(60, 2, 1'b0);
        do_drain();

        // Overflow: no pops, twice as many words as the FIFO holds.
        do_start();
        do_write(2, 1'b0);
        do_wait(MODE_LOAD, MODE_MATMUL, $urandom_range(0, 3), $urandom_range(1, 4));
        do_wait(MODE_MATMUL, MODE_READ, $urandom_range(0, 3), $urandom_range(1, 4));
        do_read(100, 1, 1'b0);
        check("ovf_sticky", 32'(err_overflow), 32'(1));

        // Reset in the middle of MATMUL with stale words still queued.
        do_start();
        do_write(0, 1'b0);
        do_wait(MODE_LOAD, MODE_MATMUL, $urandom_range(0, 3), $urandom_range(1, 4));
        sa_int = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("mid_mm_mode", 32'(mode_now()), 32'(MODE_MATMUL));
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_mode", 32'(mode_now()), 32'(MODE_READ));
        check("mid_rst_busy", 32'(busy), 32'(0));
        check("mid_rst_sa_en", 32'(sa_en), 32'(0));
        check("mid_rst_in_ready", 32'(in_ready), 32'(0));
        step();
        check("mid_rst_idle", 32'(busy), 32'(0));

        for (int j = 0; j < 6; j++) begin
            do_start();
            do_write(2, 1'b0);
            do_wait(MODE_LOAD, MODE_MATMUL, $urandom_range(0, 3), $urandom_range(1, 4));
            do_wait(MODE_MATMUL, MODE_READ, $urandom_range(0, 3), $urandom_range(1, 4));
            do_read($urandom_range(30, 100), $urandom_range(0, 2), 1'b0);
            if (j % 2 == 1) do_drain();
        end
        do_drain();

`ifdef SA_SEQ_TIMEOUT_EN
        // sa_int stuck low: LOAD must give up after TIMEOUT_CYCLES.
        do_start();
        do_write(0, 1'b0);
        sa_int = 1'b0;
        for (int i = 1; i <= TIMEOUT_CYCLES; i++) begin
            step();
            check("to_wait_done", 32'(done), 32'(0));
            check("to_wait_mode", 32'(mode_now()), 32'(MODE_LOAD));
        end
        step();
        check("to_done", 32'(done), 32'(1));
        check("to_err", 32'(err_timeout), 32'(1));
        check("to_mode", 32'(mode_now()), 32'(MODE_READ));
        step();
        check("to_idle_busy", 32'(busy), 32'(0));
        check("to_err_sticky", 32'(err_timeout), 32'(1));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
